// File: rtl/bank_read_controller_if.sv
// Bus between a read requester/banked memory/response consumer (master)
// and the bank read controller (slave).
interface bank_read_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [1:0]            bank_sel;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  mem_rd_en;
  logic [1:0]            mem_bank;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_bank;
  logic                  bank_switch;
  logic [7:0]            read_count;

  modport master (
    output bank_sel, req_valid, req_addr, mem_rd_data, rsp_ready,
    input  req_ready, mem_rd_en, mem_bank, mem_addr,
           rsp_valid, rsp_data, rsp_bank, bank_switch, read_count
  );

  modport slave (
    input  bank_sel, req_valid, req_addr, mem_rd_data, rsp_ready,
    output req_ready, mem_rd_en, mem_bank, mem_addr,
           rsp_valid, rsp_data, rsp_bank, bank_switch, read_count
  );
endinterface

// File: rtl/bank_read_controller.sv
// Single-outstanding banked read controller: accept, strobe memory,
// capture the returned word, hold it until the consumer takes it.
module bank_read_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bank_read_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

  state_t                state;
  logic                  req_ready_q;
  logic                  rd_en_q;
  logic [1:0]            bank_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]            rsp_bank_q;
  logic                  switch_q;
  logic [7:0]            count_q;
  logic [1:0]            prev_bank_q;  // bank of the last accepted request

  // FSM and all registered outputs; req_ready is only raised after the
  // first edge out of reset, so it is a register rather than a decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready_q <= 1'b0;
      rd_en_q     <= 1'b0;
      bank_q      <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_bank_q  <= '0;
      switch_q    <= 1'b0;
      count_q     <= '0;
      prev_bank_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            // bank is sampled here only; later bank_sel moves are ignored
            bank_q      <= bus.bank_sel;
            addr_q      <= bus.req_addr;
            rd_en_q     <= 1'b1;
            switch_q    <= (bus.bank_sel != prev_bank_q);
            prev_bank_q <= bus.bank_sel;
            req_ready_q <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          rd_en_q  <= 1'b0;
          switch_q <= 1'b0;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          // memory answers the cycle after the strobe
          rsp_data_q  <= bus.mem_rd_data;
          rsp_bank_q  <= bank_q;
          rsp_valid_q <= 1'b1;
          state       <= RESPOND;
        end
        RESPOND: begin
          if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_bank    = bank_q;
  assign bus.mem_addr    = addr_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_bank    = rsp_bank_q;
  assign bus.bank_switch = switch_q;
  assign bus.read_count  = count_q;

endmodule
